// File: rtl/bank_config_driver.sv
// Memory-bank configuration driver: packs a stream of config words into one
// bit-line row, then strobes that row's word line with setup/hold margins.
module bank_config_driver #(
    parameter int BL_WIDTH   = 315,
    parameter int WL_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int WL_PULSE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  cfg_valid,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    output logic [BL_WIDTH-1:0]   bl_out,
    output logic [WL_WIDTH-1:0]   wl_out,
    output logic                  busy,
    output logic                  done
);

    localparam int WPR     = (BL_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int WORD_W  = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int ROW_W   = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam int PULSE_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

    localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(WPR - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(WL_WIDTH - 1);
    localparam logic [PULSE_W-1:0] LAST_PULSE = PULSE_W'(WL_PULSE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]         state_reg, state_next;
    logic [ROW_W-1:0]   row_reg, row_next;
    logic [WORD_W-1:0]  word_reg, word_next;
    logic [PULSE_W-1:0] pulse_reg, pulse_next;
    logic               clear_row;
    logic               accept;

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        word_next  = word_reg;
        pulse_next = pulse_reg;
        clear_row  = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_LOAD;
                    row_next   = '0;
                    word_next  = '0;
                    clear_row  = 1'b1;
                end
            end
            S_LOAD: begin
                if (cfg_valid) begin
                    if (word_reg == LAST_WORD) begin
                        state_next = S_SETUP;
                    end else begin
                        word_next = word_reg + 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_next = S_PULSE;
                pulse_next = '0;
            end
            S_PULSE: begin
                if (pulse_reg == LAST_PULSE) begin
                    state_next = S_HOLD;
                end else begin
                    pulse_next = pulse_reg + 1'b1;
                end
            end
            S_HOLD: begin
                if (row_reg == LAST_ROW) begin
                    state_next = S_DONE;
                end else begin
                    state_next = S_LOAD;
                    row_next   = row_reg + 1'b1;
                    word_next  = '0;
                    clear_row  = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            row_reg   <= '0;
            word_reg  <= '0;
            pulse_reg <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            word_reg  <= word_next;
            pulse_reg <= pulse_next;
        end
    end

    assign accept = (state_reg == S_LOAD) && cfg_valid;

    // Outputs decode straight from state so wl_out drops the instant reset asserts.
    assign cfg_ready = (state_reg == S_LOAD);
    assign busy      = (state_reg == S_LOAD) || (state_reg == S_SETUP) ||
                       (state_reg == S_PULSE) || (state_reg == S_HOLD);
    assign done      = (state_reg == S_DONE);
    assign wl_out    = (state_reg == S_PULSE) ? (WL_WIDTH'(1) << row_reg) : '0;

    // One register slice per stream word; the last slice keeps only the bits that fit.
    for (genvar gi = 0; gi < WPR; gi++) begin : g_slice
        localparam int LO = gi * DATA_WIDTH;
        localparam int W  = (BL_WIDTH - LO < DATA_WIDTH) ? (BL_WIDTH - LO) : DATA_WIDTH;
        localparam logic [WORD_W-1:0] IDX = WORD_W'(gi);

        logic [W-1:0] slice_reg;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                slice_reg <= '0;
            end else if (clear_row) begin
                slice_reg <= '0;
            end else if (accept && (word_reg == IDX)) begin
                slice_reg <= cfg_data[W-1:0];
            end
        end

        assign bl_out[LO +: W] = slice_reg;
    end

endmodule

// File: tb/tb_bank_config_driver.sv
// Bench for bank_config_driver: random/directed passes compared cycle by cycle
// against a row-schedule reference model.
module tb_bank_config_driver;

    localparam int BL  = 315;
    localparam int WL  = 4;
    localparam int DW  = 32;
    localparam int P   = 2;
    localparam int WPR = (BL + DW - 1) / DW;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_ROW  = 2;
    localparam int PH_DONE = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cfg_valid;
    logic [DW-1:0] cfg_data;
    logic          cfg_ready;
    logic [BL-1:0] bl_out;
    logic [WL-1:0] wl_out;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, row, words taken, cycles since last word, expected row bits.
    int            m_phase;
    int            m_row;
    int            m_words;
    int            m_dt;
    logic [BL-1:0] m_bl;

    int lat;
    int rdy;

    always #5 clk = ~clk;

    bank_config_driver #(
        .BL_WIDTH  (BL),
        .WL_WIDTH  (WL),
        .DATA_WIDTH(DW),
        .WL_PULSE  (P)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .cfg_valid(cfg_valid),
        .cfg_data (cfg_data),
        .cfg_ready(cfg_ready),
        .bl_out   (bl_out),
        .wl_out   (wl_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WL-1:0] exp_wl();
        if (m_phase == PH_ROW && m_dt >= 2 && m_dt <= P + 1)
            return WL'(1) << m_row;
        return '0;
    endfunction

    task automatic check_model();
        chk("cfg_ready", BL'(cfg_ready), BL'(m_phase == PH_LOAD));
        chk("busy", BL'(busy), BL'(m_phase == PH_LOAD || m_phase == PH_ROW));
        chk("done", BL'(done), BL'(m_phase == PH_DONE));
        chk("wl_out", BL'(wl_out), BL'(exp_wl()));
        chk("bl_out", bl_out, m_bl);
    endtask

    task automatic model_update(input logic st, input logic v, input logic [DW-1:0] d);
        logic [BL+DW-1:0] wide;
        case (m_phase)
            PH_IDLE, PH_DONE: begin
                if (st) begin
                    m_phase = PH_LOAD;
                    m_row   = 0;
                    m_words = 0;
                    m_bl    = '0;
                end
            end
            PH_LOAD: begin
                if (v) begin
                    wide    = {{BL{1'b0}}, d} << (m_words * DW);
                    m_bl    = m_bl | wide[BL-1:0];
                    m_words = m_words + 1;
                    if (m_words == WPR) begin
                        m_phase = PH_ROW;
                        m_dt    = 1;
                    end
                end
            end
            default: begin
                if (m_dt == P + 2) begin
                    if (m_row == WL - 1) begin
                        m_phase = PH_DONE;
                    end else begin
                        m_row   = m_row + 1;
                        m_words = 0;
                        m_bl    = '0;
                        m_phase = PH_LOAD;
                    end
                end else begin
                    m_dt = m_dt + 1;
                end
            end
        endcase
    endtask

    // data_mode: 0 word index, 1 random, 2 random with packing pattern in row 0.
    // valid_mode: 0 always valid, 1 random gaps. stall_row: 5-cycle gap after word 3.
    task automatic run_pass(input int data_mode, input int valid_mode, input int stall_row,
                            input int noise, input int abort_row,
                            output int latency, output int ready_cycles);
        int cyc = 0;
        int stall_left = 0;
        bit stalled = 0;
        latency = -1;
        ready_cycles = 0;
        while (cyc < 3000) begin
            check_model();
            if (cyc > 0 && done === 1'b1) begin
                latency = cyc;
                break;
            end
            if (data_mode == 2 && m_phase == PH_ROW && m_row == 0 && m_dt == 1) begin
                chk("pack_word0", BL'(bl_out[31:0]), BL'(32'hDEADBEEF));
                chk("pack_last", BL'(bl_out[BL-1:288]), BL'({(BL-288){1'b1}}));
            end
            if (abort_row >= 0 && m_phase == PH_ROW && m_row == abort_row && m_dt == 2) begin
                start = 1'b0;
                cfg_valid = 1'b0;
                #2 reset = 1'b0;
                #1;
                chk("abort_wl", BL'(wl_out), '0);
                chk("abort_bl", bl_out, '0);
                chk("abort_busy", BL'(busy), '0);
                chk("abort_ready", BL'(cfg_ready), '0);
                @(posedge clk);
                #1 reset = 1'b1;
                m_phase = PH_IDLE;
                m_bl = '0;
                latency = cyc;
                return;
            end
            if (cfg_ready === 1'b1) ready_cycles++;

            start = (cyc == 0) ||
                    (noise != 0 && ((m_phase == PH_LOAD && m_words == 2) ||
                                    (m_phase == PH_ROW && m_dt == 2)));
            if (m_phase == PH_LOAD && m_row == stall_row && m_words == 4 && !stalled) begin
                stall_left = 5;
                stalled = 1;
            end
            if (stall_left > 0) begin
                cfg_valid = 1'b0;
                stall_left--;
            end else if (valid_mode == 1) begin
                cfg_valid = ($urandom_range(0, 3) != 0);
            end else begin
                cfg_valid = (m_phase == PH_LOAD);
            end
            if (data_mode == 0) begin
                cfg_data = DW'(m_words);
            end else if (data_mode == 2 && m_row == 0 && m_words == 0) begin
                cfg_data = 32'hDEADBEEF;
            end else if (data_mode == 2 && m_row == 0 && m_words == WPR - 1) begin
                cfg_data = 32'hFFFFFFFF;
            end else begin
                cfg_data = $urandom;
            end
            model_update(start, cfg_valid, cfg_data);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        m_phase = PH_IDLE;
        m_row = 0;
        m_words = 0;
        m_dt = 0;
        m_bl = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_bl", bl_out, '0);
        chk("rst_wl", BL'(wl_out), '0);
        chk("rst_ready", BL'(cfg_ready), '0);
        chk("rst_busy", BL'(busy), '0);
        chk("rst_done", BL'(done), '0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", BL'(cfg_ready), '0);
        chk("idle_busy", BL'(busy), '0);

        // Plain pass, index data, no stalls.
        run_pass(0, 0, -1, 0, -1, lat, rdy);
        chk("latency_a", BL'(lat), BL'(57));
        chk("ready_cycles_a", BL'(rdy), BL'(WL * WPR));

        // From DONE: packing pattern, 5-cycle stall in row 1, stray start pulses.
        run_pass(2, 0, 1, 1, -1, lat, rdy);
        chk("latency_b", BL'(lat), BL'(62));

        // Random gaps and data, aborted by reset during row 2 pulse.
        run_pass(1, 1, -1, 1, 2, lat, rdy);

        // Fresh pass after abort.
        run_pass(1, 0, -1, 0, -1, lat, rdy);
        chk("latency_d", BL'(lat), BL'(57));

        // Random gaps to completion.
        run_pass(1, 1, 2, 1, -1, lat, rdy);
        checks++;
        assert (lat > 62)
        else begin
            errors++;
            $error("FAIL latency_e: observed %0d expected above 62", lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
